// File: rtl/terrain_gen.sv
// terrain_gen: procedural artillery terrain with diamond crater deformation.
// One height per column lives in a RAM; a registered read port also yields a solid-pixel bitmap.
module terrain_gen #(
    parameter int NCOLS     = 640,
    parameter int NROWS     = 480,
    parameter int DEFAULT_H = 310,
    parameter int MIN_H     = 16,
    parameter int NOISE_W   = 10,
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int R_W       = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      seed,
    input  logic             rough,
    input  logic             gen_req,
    input  logic             crater_req,
    input  logic [X_W-1:0]   crater_x,
    input  logic [Y_W-1:0]   crater_y,
    input  logic [R_W-1:0]   crater_r,
    output logic             busy,
    output logic             done,
    input  logic [X_W-1:0]   rd_addr,
    output logic [Y_W-1:0]   rd_height,
    output logic [NROWS-1:0] rd_column
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_GEN   = 3'd1;
    localparam logic [2:0] S_IDLE  = 3'd2;
    localparam logic [2:0] S_CR_RD = 3'd3;
    localparam logic [2:0] S_CR_WR = 3'd4;

    localparam int HW = Y_W + 1;
    localparam int AW = ((X_W > Y_W) ? X_W : Y_W) + 2;

    localparam logic [X_W-1:0]        LAST_COL   = X_W'(NCOLS - 1);
    localparam logic signed [AW-1:0]  LAST_COL_S = AW'(NCOLS - 1);
    localparam logic signed [AW-1:0]  MAX_ROW_S  = AW'(NROWS - 1);
    localparam logic signed [HW-1:0]  MIN_H_S    = HW'(MIN_H);
    localparam logic signed [HW-1:0]  MAX_H_S    = HW'(NROWS - 1);

    logic [2:0]                state_q, state_d;
    logic [15:0]               lfsr_q, lfsr_d;
    logic                      mode_q, mode_d;
    logic [Y_W-1:0]            h_q, h_d;
    logic signed [NOISE_W-1:0] noise_q, noise_d;
    logic [X_W-1:0]            col_q, col_d;
    logic [X_W-1:0]            x_q, x_d;
    logic [X_W-1:0]            hi_q, hi_d;
    logic [Y_W-1:0]            y_q, y_d;
    logic [R_W-1:0]            r_q, r_d;
    logic                      done_q, done_d;

    logic [Y_W-1:0] mem [NCOLS];
    logic [Y_W-1:0] int_rd_q;
    logic [Y_W-1:0] rd_height_q;
    logic           rd_valid_q;
    logic           mem_we;
    logic [Y_W-1:0] mem_wdata;
    logic           start_gen;

    // Generator datapath: noise is a leaky signed accumulator driven by the LFSR
    logic                      lfsr_fb;
    logic signed [NOISE_W-1:0] rng_s, bias_s, noise_sum, noise_step;
    logic signed [HW-1:0]      h_sum;
    logic [Y_W-1:0]            h_clamped;

    always_comb begin
        lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        rng_s      = {{(NOISE_W-7){1'b0}}, lfsr_q[15:9]};
        bias_s     = mode_q ? NOISE_W'(58) : NOISE_W'(53);
        noise_sum  = (noise_q >>> 1) + (noise_q >>> 2) + (noise_q >>> 3) + rng_s - bias_s;
        noise_step = mode_q ? (noise_q >>> (NOISE_W - 4)) : (noise_q >>> (NOISE_W - 3));
        h_sum      = $signed({1'b0, h_q}) + HW'(noise_step);
        if (h_sum < MIN_H_S)
            h_clamped = Y_W'(MIN_H);
        else if (h_sum > MAX_H_S)
            h_clamped = Y_W'(NROWS - 1);
        else
            h_clamped = h_sum[Y_W-1:0];
    end

    // Crater datapath: column range for a new request, and the diamond depth at col_q
    logic signed [AW-1:0] req_x_s, req_r_s, lo_s, hi_s, dist_s, t_s;
    logic [Y_W-1:0]       t_val, cr_wdata;

    always_comb begin
        req_x_s = $signed(AW'(crater_x));
        req_r_s = $signed(AW'(crater_r));
        lo_s    = req_x_s - req_r_s;
        if (lo_s[AW-1])
            lo_s = '0;
        hi_s    = req_x_s + req_r_s;
        if (hi_s > LAST_COL_S)
            hi_s = LAST_COL_S;

        dist_s = $signed(AW'(col_q)) - $signed(AW'(x_q));
        if (dist_s[AW-1])
            dist_s = -dist_s;
        t_s = $signed(AW'(y_q)) + $signed(AW'(r_q)) - dist_s;
        if (t_s > MAX_ROW_S)
            t_s = MAX_ROW_S;
        t_val    = t_s[Y_W-1:0];
        cr_wdata = (t_val > int_rd_q) ? t_val : int_rd_q;
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        mode_d    = mode_q;
        h_d       = h_q;
        noise_d   = noise_q;
        col_d     = col_q;
        x_d       = x_q;
        y_d       = y_q;
        r_d       = r_q;
        hi_d      = hi_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = h_q;
        start_gen = 1'b0;

        case (state_q)
            S_INIT: start_gen = 1'b1;
            S_GEN: begin
                mem_we  = 1'b1;
                lfsr_d  = {lfsr_q[14:0], lfsr_fb};
                noise_d = noise_sum;
                h_d     = h_clamped;
                if (col_q == LAST_COL) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    col_d = col_q + X_W'(1);
                end
            end
            S_IDLE: begin
                if (gen_req) begin
                    start_gen = 1'b1;
                end else if (crater_req) begin
                    x_d  = crater_x;
                    y_d  = crater_y;
                    r_d  = crater_r;
                    hi_d = hi_s[X_W-1:0];
                    // A crater entirely right of the playfield completes without touching RAM
                    if (lo_s > hi_s) begin
                        done_d = 1'b1;
                    end else begin
                        col_d   = lo_s[X_W-1:0];
                        state_d = S_CR_RD;
                    end
                end
            end
            S_CR_RD: state_d = S_CR_WR;
            S_CR_WR: begin
                mem_we    = 1'b1;
                mem_wdata = cr_wdata;
                if (col_q == hi_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    col_d   = col_q + X_W'(1);
                    state_d = S_CR_RD;
                end
            end
            default: state_d = S_INIT;
        endcase

        if (start_gen) begin
            lfsr_d  = (seed == 16'd0) ? 16'd1 : seed;
            mode_d  = rough;
            h_d     = Y_W'(DEFAULT_H);
            noise_d = '0;
            col_d   = '0;
            state_d = S_GEN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            done_q  <= 1'b0;
            lfsr_q  <= 16'd1;
            mode_q  <= 1'b0;
            h_q     <= '0;
            noise_q <= '0;
            col_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            lfsr_q  <= lfsr_d;
            mode_q  <= mode_d;
            h_q     <= h_d;
            noise_q <= noise_d;
            col_q   <= col_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            hi_q    <= hi_d;
        end
    end

    // Read-first RAM: a read colliding with a write on the same edge sees the old height
    always_ff @(posedge clk) begin
        if (mem_we && reset_n)
            mem[col_q] <= mem_wdata;
        int_rd_q <= mem[col_q];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_height_q <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_height_q <= mem[rd_addr];
            rd_valid_q  <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < NROWS; gi++) begin : g_col
        assign rd_column[gi] = rd_valid_q && (rd_height_q <= Y_W'(gi));
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign rd_height = rd_height_q;

endmodule

// File: doc/terrain_gen.md
# terrain_gen

Parametrised terrain generator and deformer for the artillery playfield. It stores one surface height per screen column in a dual-read height RAM. On reset or on request it procedurally generates a new profile, and it carves diamond-shaped craters on request. It sits between game control and the renderer and collision logic. Those consumers read heights, or a derived solid-pixel column bitmap, through a registered read port.

## Interface
Parameters:
- NCOLS, 640, number of columns; column addresses run 0..NCOLS-1.
- NROWS, 480, number of pixel rows; heights run 0..NROWS-1, and a larger value means lower ground.
- DEFAULT_H, 310, height of column 0 at every generation.
- MIN_H, 16, minimum height (highest allowed peak).
- NOISE_W, 10, noise accumulator width; must be 8 or more.
- X_W, 10 / Y_W, 9 / R_W, 6, widths of the column address, the height and the crater radius.

Ports (clock and reset first):
- clk, in, 1, rising-edge clock.
- reset_n, in, 1, synchronous active-low reset.
- seed, in, 16, LFSR seed, sampled at each generation start.
- rough, in, 1, roughness select (0 = flat, 1 = exaggerated), sampled at each generation start.
- gen_req, in, 1, regenerate request.
- crater_req, in, 1, crater request.
- crater_x, in, X_W, crater centre column.
- crater_y, in, Y_W, crater centre row.
- crater_r, in, R_W, crater radius.
- busy, out, 1, high whenever state is not IDLE.
- done, out, 1, one-cycle pulse when a generation or crater finishes.
- rd_addr, in, X_W, external read column.
- rd_height, out, Y_W, height of rd_addr; 1-cycle latency.
- rd_column, out, NROWS, bitmap for rd_addr; bit i = 1 iff i ≥ height; 1-cycle latency.

## Operation
States are INIT, GEN, IDLE, CR_RD and CR_WR.

**INIT**
- Entered whenever reset_n is low, regardless of the current state.
- On the first edge with reset_n high:
  - lfsr loads seed; a seed of 0 is replaced with 1.
  - mode is latched from rough.
  - h is set to DEFAULT_H, noise to 0 and col to 0.
  - State moves to GEN.

**GEN**
- Each edge writes h to column col, then updates the generator registers.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting left once per GEN cycle.
- rng is lfsr[15:9], zero-extended to NOISE_W.
- Noise update, with all arithmetic signed NOISE_W and wrapping: noise ← (noise>>>1) + (noise>>>2) + (noise>>>3) + rng − BIAS.
  - mode 0: BIAS = 53, STEP = NOISE_W−3.
  - mode 1: BIAS = 58, STEP = NOISE_W−4.
- Height update: h ← clamp(h + (noise>>>STEP), MIN_H, NROWS−1).
  - The update uses the old value of noise.
  - The sum is computed signed, one bit wider than Y_W, before clamping.
- After column NCOLS−1 is written: state moves to IDLE and done pulses.

**IDLE**
- gen_req: behaves like INIT, i.e. latches seed and rough and enters GEN on the next edge.
- crater_req (with gen_req low): latch x, y and r, then compute with signed arithmetic:
  - lo = max(0, x−r)
  - hi = min(NCOLS−1, x+r)
- If lo > hi: no RAM writes; state returns to IDLE and done pulses on the next edge.
- Otherwise: col ← lo and state moves to CR_RD.
- If gen_req and crater_req are high together, gen_req wins and the crater request is dropped.
- Requests arriving while busy=1 are ignored and are not queued.

**CR_RD / CR_WR**
- CR_RD issues an internal read of col.
- CR_WR computes:
  - d = r − |col − x|
  - t = min(y + d, NROWS−1)
  - The write value is max(old, t).
- After writing, if col = hi the state moves to IDLE and done pulses; otherwise col increments and the state returns to CR_RD.

**Read port**
- The read port is independent of the FSM and is always valid.
- It returns the stored value, which may be mid-update.
- When a read and an internal write hit the same column on the same edge, the read returns the old value.

## Timing
- While reset_n is low: busy=1, done=0, rd_height=0, rd_column=0.
- Height RAM contents are not reset; they are undefined until the first generation completes.
- Generation from INIT or gen_req: busy stays high for 1 + NCOLS cycles.
  - Column c is written on edge c+1 counted from the INIT/accept edge.
  - done is high for exactly 1 cycle, coincident with busy falling.
- Crater: 1 accept cycle plus 2·(hi−lo+1) cycles, then done. An empty range takes 1 cycle.
- reset_n low mid-crater or mid-generation:
  - The operation is abandoned and partially written columns are kept.
  - On release the block regenerates.

## Test plan
1. **Reset and generate.** Reset, then release with seed=16'hACE1 and rough=0. Required:
   - busy is high for 641 cycles, then done pulses once.
   - Column 0 = 310.
   - Every height is within [16,479] and matches the reference model.
   - rd_column[i] = (i ≥ rd_height) on every column.
2. **Determinism.** gen_req twice with seed=16'h1234 and rough=1 gives identical profiles. Seed 0 gives the same profile as seed 1. rough=0 versus 1 with the same seed gives different profiles.
3. **Crater.** Crater x=100, y=400, r=10. Required:
   - busy for 43 cycles.
   - Columns 90..110 become max(old, 410−|c−100|).
   - Columns 89 and 111 are unchanged.
4. **Clipping and saturation.**
   - x=3, r=8 writes columns 0..11 only (25 busy cycles).
   - x=700, r=20 makes no writes, with done on the next cycle.
   - y=475, r=10 saturates column x to 479.
5. **Collisions.**
   - crater_req during GEN is ignored.
   - gen_req and crater_req in the same IDLE cycle → generation only.
   - A rd_addr equal to the CR_WR column returns the old height that cycle and the new height the next.
6. **Reset mid-crater.** reset_n low for 2 cycles mid-crater → busy=1, done=0, rd_height=0 during reset. On release a full 641-cycle regeneration follows.
